regfile_sb: RTL

Parametrised integer register file with write-back bypass and a per-register busy scoreboard, replacing the single-cycle register file for the pipelined core. It sits between decode and execute: decode reads operands and issues destinations, write-back writes results. A stall output holds decode while any operand or destination is pending. All state is clocked; x0 is hardwired zero.

---
 rtl/regfile_sb_pkg.sv | 23 ++
 rtl/regfile_sb_if.sv | 38 +++
 rtl/regfile_rdport.sv | 46 ++++
 rtl/regfile_sb.sv | 103 ++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sb_pkg
// Shared core constants for the integer register file: default data width,
// default register count and the ABI names of the registers that decode and
// the bench refer to by name.
// -----------------------------------------------------------------------------
package regfile_sb_pkg;

    localparam int CORE_XLEN  = 32;
    localparam int CORE_NREGS = 32;

    // ABI register indices
    localparam int ZERO = 0;
    localparam int RA   = 1;
    localparam int SP   = 2;
    localparam int GP   = 3;
    localparam int TP   = 4;
    localparam int T0   = 5;
    localparam int S0   = 8;
    localparam int A0   = 10;
    localparam int T3   = 28;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_sb_if
// Decode/write-back bus of the register file.
//   master (decode/write-back side): drives rd_addr, src_use, wr_*, iss_*,
//                                    chk_rd; receives rd_data, stall, busy
//   slave  (register file)         : the reverse
// Read port i uses rd_addr[i*AW +: AW] and rd_data[i*XLEN +: XLEN].
// -----------------------------------------------------------------------------
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic                chk_rd;
    logic [NRD-1:0]      src_use;
    logic                stall;
    logic [NREGS-1:0]    busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, chk_rd, src_use,
        input  rd_data, stall, busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, chk_rd, src_use,
        output rd_data, stall, busy
    );

endinterface : regfile_sb_if

// File: rtl/regfile_rdport.sv
// -----------------------------------------------------------------------------
// regfile_rdport
// One combinational read port: x0 returns zero, optional same-cycle forwarding
// of write-back data, and this port's contribution to the decode stall.
//   active_i  : low while reset is held; forces data_o and hazard_o to 0
//   addr_i    : register index read by this port
//   use_i     : operand is actually used (qualifies the hazard only)
//   reg_val_i : stored value of regs[addr_i]
//   busy_i    : scoreboard bit of regs[addr_i]
//   wr_*_i    : current write-back
//   data_o    : operand value
//   hazard_o  : operand is still pending
// -----------------------------------------------------------------------------
module regfile_rdport #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            active_i,
    input  logic [AW-1:0]   addr_i,
    input  logic            use_i,
    input  logic [XLEN-1:0] reg_val_i,
    input  logic            busy_i,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0] data_o,
    output logic            hazard_o
);

    logic wr_hit;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data_o   = '0;
        hazard_o = 1'b0;
        // A write-back to this address both supplies the data and retires the
        // pending producer in the same cycle, so it also masks the busy bit.
        wr_hit   = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr_i);
        if (active_i && (addr_i != '0)) begin
            data_o   = wr_hit ? wr_data_i : reg_val_i;
            hazard_o = use_i && busy_i && !wr_hit;
        end
    end

endmodule : regfile_rdport

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Integer register file with write-back bypass and per-register busy
// scoreboard. Decode reads operands and issues destinations; write-back
// writes results. stall holds decode while a used operand or the issued
// destination is still pending. x0 is hardwired zero.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears registers and busy bits
//   bus   : regfile_sb_if slave (read ports, write-back, issue, stall, busy)
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN   = CORE_XLEN,
    parameter int NREGS  = CORE_NREGS,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic             wr_fire;
    logic             iss_fire;
    logic             dest_wr_hit;
    logic             dest_hazard;

    logic [AW-1:0]    rd_addr_w [NRD];
    logic [XLEN-1:0]  rd_data_w [NRD];
    logic [NRD-1:0]   hazard_w;

    assign wr_fire  = bus.wr_en  && (bus.wr_addr != '0);
    assign iss_fire = bus.iss_en && (bus.iss_rd  != '0);

    // Scoreboard next state: clear on write-back, then set on issue, so a
    // same-edge clear/set of one register leaves the new producer pending.
    always_comb begin
        busy_d = busy_q;
        if (wr_fire) begin
            busy_d[bus.wr_addr] = 1'b0;
        end
        if (iss_fire) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the storage array is reset on purpose -- registers must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_fire) begin
                regs_q[bus.wr_addr] <= bus.wr_data;
            end
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign rd_addr_w[i] = bus.rd_addr[i*AW +: AW];

        regfile_rdport #(
            .XLEN   (XLEN),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rdport (
            .active_i  (rst_n),
            .addr_i    (rd_addr_w[i]),
            .use_i     (bus.src_use[i]),
            .reg_val_i (regs_q[rd_addr_w[i]]),
            .busy_i    (busy_q[rd_addr_w[i]]),
            .wr_en_i   (bus.wr_en),
            .wr_addr_i (bus.wr_addr),
            .wr_data_i (bus.wr_data),
            .data_o    (rd_data_w[i]),
            .hazard_o  (hazard_w[i])
        );

        assign bus.rd_data[i*XLEN +: XLEN] = rd_data_w[i];
    end

    // Destination term: issuing onto a still-pending register would be a WAW.
    always_comb begin
        dest_wr_hit = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.iss_rd);
        dest_hazard = bus.chk_rd && (bus.iss_rd != '0) && busy_q[bus.iss_rd] && !dest_wr_hit;
    end

    assign bus.stall = rst_n && ((|hazard_w) || dest_hazard);
    assign bus.busy  = busy_q;

endmodule : regfile_sb
